// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN output-feature-map write path.
package cnn_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_PACK       = 4;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ofw_state_t;

   typedef logic [DEF_PACK*DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/ofmap_writer_if.sv
// Output-SRAM write bus: word write request with a ready handshake.
interface ofmap_writer_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned PACK       = 4
);
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic [PACK-1:0]       mem_be;
   logic                  mem_ready;

   modport master (
      output mem_wr_en,
      output mem_addr,
      output mem_wdata,
      output mem_be,
      input  mem_ready
   );

   modport slave (
      input  mem_wr_en,
      input  mem_addr,
      input  mem_wdata,
      input  mem_be,
      output mem_ready
   );
endinterface

// File: rtl/ofmap_writer_fifo.sv
// Show-ahead word FIFO; a push on a full FIFO is accepted only if a pop happens on the same edge.
module ofmap_fifo #(
   parameter int unsigned Width = 36,
   parameter int unsigned Depth = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             last_o
);
   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW+1)'(Depth));
   assign empty_o = (count_q == '0);
   assign last_o  = (count_q == (PtrW+1)'(1));
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the head is qualified by empty_o downstream.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ofmap_writer.sv
// Packs activation bytes into words, buffers them, and writes them to output SRAM.
module ofmap_writer
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PACK       = DEF_PACK,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_pixels,
   input  logic                  ready_write,
   input  logic [DATA_WIDTH-1:0] act_output,
   ofmap_writer_if.master        mem,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   localparam int unsigned WordW = PACK * DATA_WIDTH;
   localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;

   ofw_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  npix_q, npix_d, byte_cnt_q, byte_cnt_d;
   logic [LaneW-1:0]      lane_q, lane_d;
   logic [WordW-1:0]      pack_q, pack_d, push_word, head_word;
   logic [PACK-1:0]       push_be, head_be;
   logic                  ovf_q, ovf_d;
   logic                  accept, is_last, word_done, pop, drained;
   logic                  fifo_full, fifo_empty, fifo_last;

   assign accept    = (state_q == RUN) && ready_write && (byte_cnt_q != npix_q);
   assign is_last   = ((byte_cnt_q + CNT_WIDTH'(1)) == npix_q);
   assign word_done = accept && ((lane_q == LaneW'(PACK - 1)) || is_last);
   assign pop       = mem.mem_wr_en && mem.mem_ready;
   // Leave DRAIN on the edge of the final pop so done follows the last write directly.
   assign drained   = fifo_empty || (pop && fifo_last);

   always_comb begin
      push_word = pack_q;
      push_be   = '0;
      for (int l = 0; l < PACK; l++) begin
         if (LaneW'(l) == lane_q) push_word[l*DATA_WIDTH +: DATA_WIDTH] = act_output;
         if (LaneW'(l) <= lane_q) push_be[l] = 1'b1;
      end
   end

   ofmap_fifo #(
      .Width (WordW + PACK),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (word_done),
      .wdata_i ({push_be, push_word}),
      .pop_i   (pop),
      .rdata_o ({head_be, head_word}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .last_o  (fifo_last)
   );

   assign mem.mem_wr_en = !fifo_empty;
   assign mem.mem_addr  = base_q + idx_q;
   assign mem.mem_wdata = fifo_empty ? '0 : head_word;
   assign mem.mem_be    = fifo_empty ? '0 : head_be;

   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign overflow = ovf_q;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      npix_d     = npix_q;
      byte_cnt_d = byte_cnt_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      idx_d      = idx_q;
      ovf_d      = ovf_q;

      if (pop) idx_d = idx_q + ADDR_WIDTH'(1);
      if (accept) begin
         byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
         if (word_done) begin
            lane_d = '0;
            pack_d = '0;
         end else begin
            lane_d = lane_q + LaneW'(1);
            pack_d = push_word;
         end
      end
      if (word_done && fifo_full && !pop) ovf_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d     = base_addr;
               npix_d     = num_pixels;
               byte_cnt_d = '0;
               lane_d     = '0;
               pack_d     = '0;
               idx_d      = '0;
               ovf_d      = 1'b0;
               state_d    = (num_pixels == '0) ? DONE : RUN;
            end
         end
         RUN:     if (word_done && is_last) state_d = DRAIN;
         DRAIN:   if (drained) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         npix_q     <= '0;
         byte_cnt_q <= '0;
         lane_q     <= '0;
         pack_q     <= '0;
         idx_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         npix_q     <= npix_d;
         byte_cnt_q <= byte_cnt_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         idx_q      <= idx_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer: packing, partial words, backpressure, overflow, reset, ignores.
module tb_ofmap_writer;
   import cnn_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] num_pixels;
   logic        ready_write;
   logic [7:0]  act_output;
   logic        busy, done, overflow;

   int checks = 0;
   int errors = 0;

   ofmap_writer_if #(.ADDR_WIDTH(16), .WORD_WIDTH(32), .PACK(4)) mem_if ();

   ofmap_writer #(
      .DATA_WIDTH (8),
      .PACK       (4),
      .ADDR_WIDTH (16),
      .CNT_WIDTH  (16),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .num_pixels  (num_pixels),
      .ready_write (ready_write),
      .act_output  (act_output),
      .mem         (mem_if),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Write/done monitor, sampled on the falling edge.
   logic [15:0] wq_addr[$];
   logic [31:0] wq_data[$];
   logic [3:0]  wq_be[$];
   int cyc = 0, done_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, done_cyc = 0;
   logic done_busy = 1'b0;

   always @(negedge clk) begin
      if (mem_if.mem_wr_en && mem_if.mem_ready) begin
         wq_addr.push_back(mem_if.mem_addr);
         wq_data.push_back(mem_if.mem_wdata);
         wq_be.push_back(mem_if.mem_be);
         last_wr_cyc = cyc;
      end
      if (mem_if.mem_wr_en) wr_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = busy;
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [15:0] b, input logic [15:0] n);
      start      = 1'b1;
      base_addr  = b;
      num_pixels = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bytes(input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) begin
         ready_write = 1'b1;
         act_output  = first + 8'(i);
         tick();
      end
      ready_write = 1'b0;
   endtask

   task automatic wait_done(input int prev, input string tag);
      int n = 0;
      while (done_cnt == prev && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done_cnt > prev), 64'd1);
      tick();
   endtask

   function automatic word_t exp_word(input int k);
      word_t w;
      w = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
      return w;
   endfunction

   initial begin
      int b0, d0, w0;
      rst_n = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_pixels = '0;
      ready_write = 1'b0;
      act_output = '0;
      mem_if.mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs", {mem_if.mem_wr_en, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be,
                              busy, done, overflow}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      mem_if.mem_ready = 1'b1;

      // 1: eight bytes, two full words
      b0 = wq_addr.size();
      d0 = done_cnt;
      start_job(16'h0100, 16'd8);
      check("t1_busy", busy, 1);
      send_bytes(3, 8'h01);
      check("t1_no_wr_partial", mem_if.mem_wr_en, 0);
      send_bytes(1, 8'h04);
      check("t1_wr_latency", mem_if.mem_wr_en, 1);
      check("t1_head_data", mem_if.mem_wdata, 32'h04030201);
      send_bytes(4, 8'h05);
      wait_done(d0, "t1");
      check("t1_nwrites", wq_addr.size() - b0, 2);
      check("t1_addr0", wq_addr[b0], 16'h0100);
      check("t1_data0", wq_data[b0], 32'h04030201);
      check("t1_be0", wq_be[b0], 4'hF);
      check("t1_addr1", wq_addr[b0+1], 16'h0101);
      check("t1_data1", wq_data[b0+1], 32'h08070605);
      check("t1_be1", wq_be[b0+1], 4'hF);
      check("t1_done_timing", done_cyc, last_wr_cyc + 1);
      check("t1_busy_at_done", done_busy, 0);
      tick();
      check("t1_done_once", done_cnt - d0, 1);

      // 2: partial final word
      b0 = wq_addr.size();
      d0 = done_cnt;
      start_job(16'h0200, 16'd6);
      send_bytes(6, 8'h01);
      wait_done(d0, "t2");
      check("t2_nwrites", wq_addr.size() - b0, 2);
      check("t2_data1", wq_data[b0+1], 32'h00000605);
      check("t2_be1", wq_be[b0+1], 4'b0011);
      check("t2_addr1", wq_addr[b0+1], 16'h0201);

      // 3: backpressure fills the FIFO, then a ninth word overflows
      b0 = wq_addr.size();
      d0 = done_cnt;
      mem_if.mem_ready = 1'b0;
      start_job(16'h0300, 16'd36);
      send_bytes(32, 8'h01);
      check("t3_wr_pending", mem_if.mem_wr_en, 1);
      check("t3_no_ovf_at_8", overflow, 0);
      send_bytes(4, 8'h21);
      check("t3_ovf", overflow, 1);
      check("t3_none_written", wq_addr.size() - b0, 0);
      mem_if.mem_ready = 1'b1;
      wait_done(d0, "t3");
      check("t3_nwrites", wq_addr.size() - b0, 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t3_addr%0d", k), wq_addr[b0+k], 16'h0300 + 16'(k));
         check($sformatf("t3_data%0d", k), wq_data[b0+k], exp_word(k));
      end
      check("t3_ovf_sticky", overflow, 1);

      // 4: empty job
      w0 = wr_cnt;
      start_job(16'h0400, 16'd0);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_ovf_cleared", overflow, 0);
      tick();
      check("t4_done_pulse", done, 0);
      tick();
      check("t4_no_wr", wr_cnt - w0, 0);

      // 5: asynchronous reset mid-job, then a clean job
      mem_if.mem_ready = 1'b0;
      start_job(16'h0500, 16'd8);
      send_bytes(5, 8'h01);
      check("t5_pre_busy", busy, 1);
      check("t5_pre_wr", mem_if.mem_wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_reset_outputs", {mem_if.mem_wr_en, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be,
                                 busy, done, overflow}, 64'd0);
      tick();
      rst_n = 1'b1;
      mem_if.mem_ready = 1'b1;
      tick();
      b0 = wq_addr.size();
      d0 = done_cnt;
      start_job(16'h0600, 16'd4);
      send_bytes(4, 8'hA1);
      wait_done(d0, "t5");
      check("t5_nwrites", wq_addr.size() - b0, 1);
      check("t5_addr", wq_addr[b0], 16'h0600);
      check("t5_data", wq_data[b0], 32'hA4A3A2A1);
      check("t5_be", wq_be[b0], 4'hF);

      // 6: start during RUN and extra bytes are ignored
      b0 = wq_addr.size();
      d0 = done_cnt;
      start_job(16'h0700, 16'd8);
      send_bytes(4, 8'h01);
      start       = 1'b1;
      base_addr   = 16'h07F0;
      num_pixels  = 16'd2;
      ready_write = 1'b1;
      act_output  = 8'h05;
      tick();
      start = 1'b0;
      send_bytes(6, 8'h06);
      wait_done(d0, "t6");
      check("t6_nwrites", wq_addr.size() - b0, 2);
      check("t6_addr0", wq_addr[b0], 16'h0700);
      check("t6_data0", wq_data[b0], 32'h04030201);
      check("t6_addr1", wq_addr[b0+1], 16'h0701);
      check("t6_data1", wq_data[b0+1], 32'h08070605);
      send_bytes(2, 8'hEE);
      tick();
      tick();
      check("t6_idle_bytes_dropped", wq_addr.size() - b0, 2);

      // 7: full FIFO with push and pop on the same edges
      b0 = wq_addr.size();
      d0 = done_cnt;
      mem_if.mem_ready = 1'b0;
      start_job(16'h0800, 16'd48);
      send_bytes(32, 8'h01);
      for (int i = 32; i < 48; i++) begin
         mem_if.mem_ready = ((i % 4) == 3);
         ready_write      = 1'b1;
         act_output       = 8'(i + 1);
         tick();
      end
      ready_write = 1'b0;
      mem_if.mem_ready = 1'b1;
      check("t7_no_ovf", overflow, 0);
      wait_done(d0, "t7");
      check("t7_nwrites", wq_addr.size() - b0, 12);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("t7_addr%0d", k), wq_addr[b0+k], 16'h0800 + 16'(k));
         check($sformatf("t7_data%0d", k), wq_data[b0+k], exp_word(k));
      end
      check("t7_ovf_end", overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
